// File: rtl/spi_cmd_frontend_if.sv
`timescale 1ns/1ps
// SPI command front-end bundle: raw SPI pins plus the decoder-side frame outputs.
// Latency: none, wiring only.
// Backpressure: none; the decoder must take each cmd_valid pulse as it arrives.
// Ports (slave = front-end view):
//   spi_sclk/spi_cs_n/spi_mosi in, spi_miso out             raw SPI pins, mode 0
//   cmd_word/data_word out                                  fields of the last accepted frame
//   cmd_valid/frame_err out                                 one-cycle accept / reject pulses
//   frame_cnt out                                           8-bit accepted-frame counter
interface spi_cmd_frontend_if #(
  parameter int CMD_WIDTH      = 8,
  parameter int DATAWORD_WIDTH = 16
);
  logic                      spi_sclk;
  logic                      spi_cs_n;
  logic                      spi_mosi;
  logic                      spi_miso;
  logic [CMD_WIDTH-1:0]      cmd_word;
  logic [DATAWORD_WIDTH-1:0] data_word;
  logic                      cmd_valid;
  logic                      frame_err;
  logic [7:0]                frame_cnt;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output spi_miso, cmd_word, data_word, cmd_valid, frame_err, frame_cnt
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  spi_miso, cmd_word, data_word, cmd_valid, frame_err, frame_cnt
  );
endinterface

// File: rtl/spi_cmd_frontend.sv
`timescale 1ns/1ps
// Purpose: synchronise raw SPI pins, assemble 8+16-bit command frames, length-check, emit to decoder.
// Latency: cmd_valid/frame_err rises SYNC_STAGES+2 sys_clk edges after the first edge sampling cs_n high.
// Backpressure: none; one-cycle pulses, outputs hold until the next accepted frame.
// Ports: sys_clk, rst_n (async active-low) plain; everything else through bus (spi_cmd_frontend_if.slave).
// Optional: define CMD_READBACK_EN to shift the previously accepted frame out on spi_miso;
//           otherwise spi_miso is tied low.
module spi_cmd_frontend #(
  parameter int CMD_WIDTH      = 8,
  parameter int DATAWORD_WIDTH = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  spi_cmd_frontend_if.slave bus
);

  localparam int FRAME_BITS = CMD_WIDTH + DATAWORD_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Pin synchronisers. cs_n resets low so that a cs_n held low through reset
  // never looks like a fresh falling edge once reset releases.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_hist_q;
  logic                   cs_hist_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;

  state_t                    state_q;
  logic [FRAME_BITS-1:0]     shift_q;
  logic [CNT_W-1:0]          bit_cnt_q;
  logic [CMD_WIDTH-1:0]      cmd_word_q;
  logic [DATAWORD_WIDTH-1:0] data_word_q;
  logic                      cmd_valid_q;
  logic                      frame_err_q;
  logic [7:0]                frame_cnt_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      cmd_word_q  <= '0;
      data_word_q <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= SHIFT;
            shift_q   <= '0;
            bit_cnt_q <= '0;
          end
        end
        SHIFT: begin
          // cs_n rising wins over a coincident sclk edge: that edge is not a data bit.
          if (cs_rise) begin
            state_q <= DONE;
          end else if (sclk_rise) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], mosi_s};
            // Saturate one past a full frame so long frames stay distinguishable.
            if (bit_cnt_q != CNT_OVF) begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (bit_cnt_q == CNT_FULL) begin
            cmd_word_q  <= shift_q[FRAME_BITS-1:DATAWORD_WIDTH];
            data_word_q <= shift_q[DATAWORD_WIDTH-1:0];
            cmd_valid_q <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 8'd1;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_word  = cmd_word_q;
  assign bus.data_word = data_word_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.frame_cnt = frame_cnt_q;

`ifdef CMD_READBACK_EN
  // Readback: snapshot of the last accepted frame, presented MSB first while the
  // host clocks in the next frame. Shift on sclk falling so the next bit is
  // settled well before the host samples on the rising edge.
  logic                  sclk_fall;
  logic [FRAME_BITS-1:0] rb_q;

  assign sclk_fall = ~sclk_s & sclk_hist_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_q <= '0;
    end else if (state_q == IDLE && cs_fall) begin
      rb_q <= {cmd_word_q, data_word_q};
    end else if (state_q == SHIFT && sclk_fall) begin
      rb_q <= {rb_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign bus.spi_miso = (state_q == SHIFT) & rb_q[FRAME_BITS-1];
`else
  assign bus.spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_frontend.sv
`timescale 1ns/1ps
// Directed bench for spi_cmd_frontend: reset, good/bad frames, cs_n low through reset,
// mid-frame reset, 256 back-to-back frames with counter wrap, MISO readback.
// SPI clock runs at sys_clk/6; every check is against hand-computed values.
module tb_spi_cmd_frontend;
  localparam int S    = 2;
  localparam int HALF = 3;
  localparam int LAT  = S + 2;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;

  spi_cmd_frontend_if #(.CMD_WIDTH(8), .DATAWORD_WIDTH(16)) bus ();

  spi_cmd_frontend #(
    .CMD_WIDTH(8),
    .DATAWORD_WIDTH(16),
    .SYNC_STAGES(S)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  // Pulse / hold monitor, sampled on the falling edge.
  int n_vld = 0, n_err = 0, n_both = 0, n_long = 0, n_hold = 0, n_miso = 0;
  int since_vld = 0, min_gap = 1000000;
  bit seen_vld = 0;
  logic prev_vld = 1'b0, prev_err = 1'b0;
  logic [7:0]  prev_cmd;
  logic [15:0] prev_data;

  always @(negedge sys_clk) begin
    since_vld++;
    if (bus.cmd_valid) begin
      n_vld++;
      if (seen_vld && since_vld < min_gap) min_gap = since_vld;
      since_vld = 0;
      seen_vld  = 1;
    end
    if (bus.frame_err) n_err++;
    if (bus.cmd_valid && bus.frame_err) n_both++;
    if ((bus.cmd_valid && prev_vld) || (bus.frame_err && prev_err)) n_long++;
    if (rst_n && !bus.cmd_valid && (bus.cmd_word !== prev_cmd || bus.data_word !== prev_data)) n_hold++;
    if (bus.spi_miso === 1'b1) n_miso++;
    prev_vld  = bus.cmd_valid;
    prev_err  = bus.frame_err;
    prev_cmd  = bus.cmd_word;
    prev_data = bus.data_word;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset(input logic cs_level);
    @(negedge sys_clk); #2;
    rst_n        = 1'b0;
    bus.spi_cs_n = cs_level;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    wait_clks(4);
    #2 rst_n = 1'b1;
    wait_clks(8);
  endtask

  // Clock nbits of 'bits' MSB first, raise cs_n, then watch 12 edges for the result pulse.
  // lat = edge number (1 = first edge sampling cs_n high) where a pulse is first seen, 0 if none.
  task automatic send_frame(input logic [31:0] bits, input int nbits, input bit lower_cs,
                            output int lat, output logic [31:0] miso_bits);
    miso_bits = '0;
    lat       = 0;
    if (lower_cs) begin
      bus.spi_cs_n = 1'b0;
      wait_clks(2 * HALF);
    end
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.spi_mosi = bits[i];
      wait_clks(HALF);
      miso_bits    = {miso_bits[30:0], bus.spi_miso};
      bus.spi_sclk = 1'b1;
      wait_clks(HALF);
      bus.spi_sclk = 1'b0;
    end
    wait_clks(HALF);
    bus.spi_cs_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge sys_clk); #1;
      if (lat == 0 && (bus.cmd_valid === 1'b1 || bus.frame_err === 1'b1)) lat = k;
    end
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    rst_n        = 1'b0;
    wait_clks(3);
    checks++; if (bus.cmd_word !== 8'h00) begin failures++; $display("FAIL reset_cmd_word: got %h want 00", bus.cmd_word); end
    checks++; if (bus.data_word !== 16'h0000) begin failures++; $display("FAIL reset_data_word: got %h want 0000", bus.data_word); end
    checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid: got %b want 0", bus.cmd_valid); end
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
    checks++; if (bus.frame_cnt !== 8'h00) begin failures++; $display("FAIL reset_frame_cnt: got %h want 00", bus.frame_cnt); end
    checks++; if (bus.spi_miso !== 1'b0) begin failures++; $display("FAIL reset_spi_miso: got %b want 0", bus.spi_miso); end
    #2 rst_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic test_good_frame();
    int lat, v0, e0;
    logic [31:0] mb;
    v0 = n_vld; e0 = n_err;
    send_frame({8'h00, 8'h23, 16'h1ABC}, 24, 1'b1, lat, mb);
    checks++; if (lat != LAT) begin failures++; $display("FAIL good_latency: got %0d want %0d", lat, LAT); end
    checks++; if (bus.cmd_word !== 8'h23) begin failures++; $display("FAIL good_cmd_word: got %h want 23", bus.cmd_word); end
    checks++; if (bus.data_word !== 16'h1ABC) begin failures++; $display("FAIL good_data_word: got %h want 1abc", bus.data_word); end
    checks++; if (bus.frame_cnt !== 8'd1) begin failures++; $display("FAIL good_frame_cnt: got %0d want 1", bus.frame_cnt); end
    checks++; if (n_vld - v0 != 1) begin failures++; $display("FAIL good_valid_pulses: got %0d want 1", n_vld - v0); end
    checks++; if (n_err - e0 != 0) begin failures++; $display("FAIL good_err_pulses: got %0d want 0", n_err - e0); end
  endtask

  task automatic test_bad_length();
    int lat23, lat25, v0, e0;
    logic [31:0] mb;
    v0 = n_vld; e0 = n_err;
    send_frame(32'h0055_AA55, 23, 1'b1, lat23, mb);
    send_frame(32'h01FF_0F0F, 25, 1'b1, lat25, mb);
    checks++; if (n_err - e0 != 2) begin failures++; $display("FAIL bad_err_pulses: got %0d want 2", n_err - e0); end
    checks++; if (n_vld - v0 != 0) begin failures++; $display("FAIL bad_valid_pulses: got %0d want 0", n_vld - v0); end
    checks++; if (lat23 != LAT || lat25 != LAT) begin failures++; $display("FAIL bad_err_latency: got %0d/%0d want %0d", lat23, lat25, LAT); end
    checks++; if (bus.cmd_word !== 8'h23 || bus.data_word !== 16'h1ABC) begin failures++; $display("FAIL bad_words_held: got %h/%h want 23/1abc", bus.cmd_word, bus.data_word); end
    checks++; if (bus.frame_cnt !== 8'd1) begin failures++; $display("FAIL bad_frame_cnt: got %0d want 1", bus.frame_cnt); end
  endtask

  task automatic test_cs_low_at_reset();
    int lat, v0, e0;
    logic [31:0] mb;
    do_reset(1'b0);
    v0 = n_vld; e0 = n_err;
    send_frame({8'h00, 8'h5C, 16'h7E81}, 24, 1'b0, lat, mb);
    checks++; if (n_vld - v0 != 0 || n_err - e0 != 0) begin failures++; $display("FAIL cslow_no_pulse: got vld=%0d err=%0d want 0/0", n_vld - v0, n_err - e0); end
    checks++; if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL cslow_frame_cnt: got %0d want 0", bus.frame_cnt); end
    send_frame({8'h00, 8'hA5, 16'h5A3C}, 24, 1'b1, lat, mb);
    checks++; if (bus.cmd_word !== 8'hA5 || bus.data_word !== 16'h5A3C) begin failures++; $display("FAIL cslow_next_words: got %h/%h want a5/5a3c", bus.cmd_word, bus.data_word); end
    checks++; if (bus.frame_cnt !== 8'd1 || n_vld - v0 != 1) begin failures++; $display("FAIL cslow_next_accept: got cnt=%0d vld=%0d want 1/1", bus.frame_cnt, n_vld - v0); end
  endtask

  task automatic test_reset_mid_frame();
    int lat, v0, e0;
    logic [31:0] mb;
    logic [11:0] part;
    part = 12'hB6D;
    bus.spi_cs_n = 1'b0;
    wait_clks(2 * HALF);
    for (int i = 11; i >= 0; i--) begin
      bus.spi_mosi = part[i];
      wait_clks(HALF);
      bus.spi_sclk = 1'b1;
      wait_clks(HALF);
      bus.spi_sclk = 1'b0;
    end
    v0 = n_vld; e0 = n_err;
    @(negedge sys_clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.cmd_word !== 8'h00 || bus.data_word !== 16'h0000) begin failures++; $display("FAIL midrst_words: got %h/%h want 00/0000", bus.cmd_word, bus.data_word); end
    checks++; if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL midrst_frame_cnt: got %0d want 0", bus.frame_cnt); end
    bus.spi_cs_n = 1'b1;
    wait_clks(4);
    #2 rst_n = 1'b1;
    wait_clks(8);
    checks++; if (n_vld - v0 != 0 || n_err - e0 != 0) begin failures++; $display("FAIL midrst_no_pulse: got vld=%0d err=%0d want 0/0", n_vld - v0, n_err - e0); end
    send_frame({8'h00, 8'hFF, 16'hFFFF}, 24, 1'b1, lat, mb);
    checks++; if (bus.cmd_word !== 8'hFF || bus.data_word !== 16'hFFFF) begin failures++; $display("FAIL midrst_next_words: got %h/%h want ff/ffff", bus.cmd_word, bus.data_word); end
    checks++; if (bus.frame_cnt !== 8'd1 || lat != LAT) begin failures++; $display("FAIL midrst_next_accept: got cnt=%0d lat=%0d want 1/%0d", bus.frame_cnt, lat, LAT); end
  endtask

  task automatic test_back_to_back();
    int lat, v0, e0, bad_lat, cnt255;
    logic [7:0]  c;
    logic [15:0] d;
    logic [31:0] mb;
    do_reset(1'b1);
    v0 = n_vld; e0 = n_err; bad_lat = 0; cnt255 = -1;
    c = 8'h00; d = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      c = 8'(i);
      d = 16'(i * 257) ^ 16'h5A5A;
      send_frame({8'h00, c, d}, 24, 1'b1, lat, mb);
      if (lat != LAT) bad_lat++;
      if (i == 254) cnt255 = int'(bus.frame_cnt);
    end
    checks++; if (cnt255 != 255) begin failures++; $display("FAIL b2b_cnt_255: got %0d want 255", cnt255); end
    checks++; if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL b2b_cnt_wrap: got %0d want 0", bus.frame_cnt); end
    checks++; if (n_vld - v0 != 256 || n_err - e0 != 0) begin failures++; $display("FAIL b2b_pulses: got vld=%0d err=%0d want 256/0", n_vld - v0, n_err - e0); end
    checks++; if (bad_lat != 0) begin failures++; $display("FAIL b2b_latency: got %0d bad frames want 0", bad_lat); end
    checks++; if (bus.cmd_word !== 8'hFF || bus.data_word !== 16'hA5A5) begin failures++; $display("FAIL b2b_last_words: got %h/%h want ff/a5a5", bus.cmd_word, bus.data_word); end
    checks++; if (min_gap < 12) begin failures++; $display("FAIL b2b_pulse_gap: got %0d want >=12", min_gap); end
  endtask

  task automatic test_miso();
    int lat;
    logic [31:0] mb;
    send_frame({8'h00, 8'h11, 16'h2233}, 24, 1'b1, lat, mb);
    send_frame({8'h00, 8'h44, 16'h5566}, 24, 1'b1, lat, mb);
    checks++; if (bus.cmd_word !== 8'h44 || bus.data_word !== 16'h5566) begin failures++; $display("FAIL miso_words: got %h/%h want 44/5566", bus.cmd_word, bus.data_word); end
`ifdef CMD_READBACK_EN
    checks++; if (mb[23:0] !== 24'h112233) begin failures++; $display("FAIL miso_readback: got %h want 112233", mb[23:0]); end
`else
    checks++; if (n_miso != 0 || mb !== 32'h0) begin failures++; $display("FAIL miso_tied_low: got %0d high samples want 0", n_miso); end
`endif
  endtask

  task automatic test_pulse_rules();
    checks++; if (n_both != 0) begin failures++; $display("FAIL pulse_overlap: got %0d want 0", n_both); end
    checks++; if (n_long != 0) begin failures++; $display("FAIL pulse_width: got %0d long pulses want 0", n_long); end
    checks++; if (n_hold != 0) begin failures++; $display("FAIL word_hold: got %0d changes without cmd_valid want 0", n_hold); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_length();
    test_cs_low_at_reset();
    test_reset_mid_frame();
    test_back_to_back();
    test_miso();
    test_pulse_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

endmodule
